// File: rtl/booth_pkg.sv
// Shared types and sizes for the radix-4 Booth sequential multiplier.
package booth_pkg;

  localparam int OP_W   = 32;
  localparam int EXT_W  = 34;
  localparam int ACC_W  = 2 * EXT_W;
  localparam int DIGITS = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two-bit extension gives the top radix-4 digit room for unsigned operands.
  function automatic logic [EXT_W-1:0] ext34(input logic [OP_W-1:0] v, input logic sgn);
    return {{(EXT_W-OP_W){sgn & v[OP_W-1]}}, v};
  endfunction

endpackage

// File: rtl/booth_seq_mul_ctrl_if.sv
// Operand/result handshake bundle for booth_seq_mul_ctrl, plus FSM debug state.
interface booth_seq_mul_ctrl_if;
  import booth_pkg::*;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; the source holds its payload stable until that edge.
  logic                in_valid;
  logic                in_ready;
  logic [OP_W-1:0]     op1;
  logic [OP_W-1:0]     op2;
  logic                s_or_us;
  logic                abort;
  logic                out_valid;
  logic                out_ready;
  logic [2*OP_W-1:0]   result;
  logic                busy;
  state_t              dbg_state;

  modport slave (
    input  in_valid, op1, op2, s_or_us, abort, out_ready,
    output in_ready, out_valid, result, busy, dbg_state
  );

  modport master (
    output in_valid, op1, op2, s_or_us, abort, out_ready,
    input  in_ready, out_valid, result, busy, dbg_state
  );
endinterface

// File: rtl/booth_digit_pp.sv
// Recodes radix-4 Booth digit k of y and selects the signed partial product 0/+-m/+-2m.
module booth_digit_pp
  import booth_pkg::*;
(
  input  logic [EXT_W-1:0] y,
  input  logic [EXT_W-1:0] m,
  input  logic [4:0]       k,
  output logic [ACC_W-1:0] pp
);

  logic [EXT_W:0]   y_ext;
  logic [5:0]       base;
  logic [2:0]       trip;
  logic             one;
  logic             two;
  logic             sgn;
  logic [ACC_W-1:0] m_wide;
  logic [ACC_W-1:0] mag;

  // y_ext[0] stands in for y[-1], so digit k reads y_ext[2k+2:2k].
  assign y_ext  = {y, 1'b0};
  assign base   = {k, 1'b0};
  assign trip   = y_ext[base +: 3];
  assign one    = trip[0] ^ trip[1];
  assign two    = ~one & (trip[1] ^ trip[2]);
  assign sgn    = trip[2];
  assign m_wide = {{(ACC_W-EXT_W){m[EXT_W-1]}}, m};

  always_comb begin
    mag = '0;
    if (two)      mag = m_wide << 1;
    else if (one) mag = m_wide;
    pp = sgn ? (~mag + 1'b1) : mag;
  end

endmodule

// File: rtl/booth_seq_mul_ctrl.sv
// Sequential 32x32 radix-4 Booth multiplier: one digit per cycle, 17 cycles per product.
module booth_seq_mul_ctrl
  import booth_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  booth_seq_mul_ctrl_if.slave  bus
);

  state_t             state_q, state_d;
  logic [4:0]         k_q, k_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [EXT_W-1:0]   y_q, y_d;
  logic [EXT_W-1:0]   m_q, m_d;
  logic [2*OP_W-1:0]  result_q, result_d;
  logic [ACC_W-1:0]   pp;

  booth_digit_pp u_digit (
    .y  (y_q),
    .m  (m_q),
    .k  (k_q),
    .pp (pp)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    acc_d    = acc_q;
    y_d      = y_q;
    m_d      = m_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          y_d     = ext34(bus.op2, bus.s_or_us);
          m_d     = ext34(bus.op1, bus.s_or_us);
          acc_d   = '0;
          k_d     = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_q + (pp << {k_q, 1'b0});
          if (k_q == 5'(DIGITS - 1)) begin
            result_d = acc_d[2*OP_W-1:0];
            state_d  = DONE;
          end else begin
            k_d = k_q + 5'd1;
          end
        end
      end
      DONE: begin
        // No accept here even with out_ready high; IDLE must be visited first.
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      acc_q    <= '0;
      y_q      <= '0;
      m_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      y_q      <= y_d;
      m_q      <= m_d;
      result_q <= result_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == ITER) || (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_booth_seq_mul_ctrl.sv
// Directed-vector bench for booth_seq_mul_ctrl with hand-computed products.
module tb_booth_seq_mul_ctrl;
  import booth_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [63:0] exp_q[$];

  booth_seq_mul_ctrl_if bus ();

  booth_seq_mul_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drivers
  task automatic accept_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op1      = a;
    bus.op2      = b;
    bus.s_or_us  = s;
    chk("accept_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    // Scramble inputs while the operation runs; latched operands must not move.
    bus.op1      = $urandom;
    bus.op2      = $urandom;
    bus.s_or_us  = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.out_valid && lat < 40);
    chk("done_seen", 64'(bus.out_valid), 64'd1);
  endtask

  task automatic take_result(input string tag);
    logic [63:0] exp;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    chk(tag, bus.result, exp);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("back_to_idle", 64'(bus.dbg_state), 64'(IDLE));
    chk("out_valid_drop", 64'(bus.out_valid), 64'd0);
  endtask

  task automatic run_full(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] exp);
    int lat;
    exp_q.push_back(exp);
    accept_op(a, b, s);
    wait_done(lat);
    chk("latency", 64'(lat), 64'd17);
    take_result(tag);
  endtask

  task automatic watch_no_valid(input int cycles, input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    int lat;
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op1       = '0;
    bus.op2       = '0;
    bus.s_or_us   = 1'b0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_result", bus.result, 64'd0);
    chk("rst_state", 64'(bus.dbg_state), 64'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Main function vectors
    run_full("u_3x5", 32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F);
    run_full("s_m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
    run_full("u_maxxmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    run_full("s_minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    run_full("s_minx1", 32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000);
    run_full("u_mixed", 32'h1234_5678, 32'h0000_0010, 1'b0, 64'h0000_0001_2345_6780);

    // Back-pressure in DONE with a new request already waiting
    exp_q.push_back(64'h0000_0001_2345_6780);
    accept_op(32'h0000_0010, 32'h1234_5678, 1'b0);
    wait_done(lat);
    chk("bp_latency", 64'(lat), 64'd17);
    bus.in_valid = 1'b1;
    bus.op1      = 32'd2;
    bus.op2      = 32'd2;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_result", bus.result, exp_q[0]);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    chk("bp_result_final", bus.result, exp_q.pop_front());
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("bp_idle", 64'(bus.dbg_state), 64'(IDLE));
    chk("bp_no_accept", 64'(bus.busy), 64'd0);
    chk("bp_in_ready_after", 64'(bus.in_ready), 64'd1);

    // Abort at k=8
    accept_op(32'h0000_AAAA, 32'h0000_5555, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    chk("abort_in_iter", 64'(bus.dbg_state), 64'(ITER));
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    watch_no_valid(20, "abort_no_valid");
    run_full("u_7x9", 32'd7, 32'd9, 1'b0, 64'd63);

    // Asynchronous reset at k=5
    accept_op(32'h0000_1234, 32'h0000_5678, 1'b1);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_result", bus.result, 64'd0);
    chk("arst_state", 64'(bus.dbg_state), 64'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
    watch_no_valid(20, "arst_no_valid");
    run_full("s_m7x6", 32'hFFFF_FFF9, 32'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_seq_mul_ctrl.md
BOOTH_SEQ_MUL_CTRL -- requirements
Module: booth_seq_mul_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk, rst_n.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  operand pair offered.
REQ-005 SHALL have port in_ready  output  1  controller can accept operands.
REQ-006 SHALL have port op1  input  32  multiplicand.
REQ-007 SHALL have port op2  input  32  multiplier (Booth-recoded operand).
REQ-008 SHALL have port s_or_us  input  1  1 = signed x signed, 0 = unsigned x unsigned.
REQ-009 SHALL have port abort  input  1  synchronous cancel of the operation in flight.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port result  output  64  product.
REQ-013 SHALL have port busy  output  1  high in ITER or DONE.

Function
REQ-014 SHALL implement the FSM states IDLE, ITER and DONE; in_ready = (state==IDLE).
REQ-015 SHALL, in IDLE on in_valid&in_ready, latch op1/op2/s_or_us, load y = 34-bit extension of op2 (sign-extend if s_or_us, else zero-extend), load m = 34-bit extension of op1 by the same rule, clear acc and k, and go to ITER.
REQ-016 SHALL, per ITER cycle, recode digit k (0..16) from y[2k+1], y[2k], y[2k-1] (y[-1]=0): one = y[2k-1]^y[2k]; two = ~one & (y[2k]^y[2k+1]); sign = y[2k+1].
REQ-017 SHALL form the partial product as 0, m or 2m when one/two select them, negate it when sign=1 (two's complement, 68-bit), and add it to acc shifted left by 2k, with acc 68 bits wide and wrap-around.
REQ-018 SHALL use a 5-bit k counter; after the update with k=16 it SHALL enter DONE, giving 17 ITER cycles.
REQ-019 SHALL give a latency of 17 clocks: for acceptance at edge E0, out_valid rises after edge E17.
REQ-020 SHALL, in DONE, drive result = acc[63:0] and out_valid=1, holding both stable until out_ready=1; DONE->IDLE on that edge.
REQ-021 SHALL NOT accept new operands in DONE, even when out_ready=1 in the same cycle; the next accept is earliest one cycle later.
REQ-022 SHALL, on abort=1 in ITER, go to IDLE next edge with no out_valid pulse; abort SHALL be ignored in IDLE and DONE.
REQ-023 SHALL keep result stable at its last value while in IDLE and ITER; result updates only on entry to DONE.
REQ-024 SHALL NOT change latched operands when input values change during ITER.

Reset
REQ-025 SHALL, on rst_n low, immediately set state=IDLE, k=0, acc=0, result=0, out_valid=0, busy=0, in_ready=1 after release.
REQ-026 SHALL, on reset mid-ITER or mid-DONE, discard the operation with no output produced.

Structure
REQ-027 SHALL put the FSM state enum, the digit count (17), the operand width (32) and the extended width (34) in shared package booth_pkg.
REQ-028 SHALL implement the digit recode plus partial-product select/negate of REQ-016/017 as one combinational sub-module, booth_digit_pp; the FSM, counter and accumulator SHALL stay in the top.

Verification
REQ-029 SHALL cover: unsigned 3 x 5 -> result 0x000000000000000F, out_valid 17 cycles after accept.
REQ-030 SHALL cover: signed 0xFFFFFFFF x 0xFFFFFFFF -> 0x0000000000000001; the same operands unsigned -> 0xFFFFFFFE00000001.
REQ-031 SHALL cover: signed 0x80000000 x 0x80000000 -> 0x4000000000000000; signed 0x80000000 x 0x00000001 -> 0xFFFFFFFF80000000.
REQ-032 SHALL cover: out_ready held low 5 cycles in DONE -> out_valid and result stable, in_ready=0 throughout, IDLE one edge after out_ready.
REQ-033 SHALL cover: abort at k=8 -> no out_valid, in_ready=1 next cycle, and the next operation 7 x 9 returns 63.
REQ-034 SHALL cover: rst_n low at k=5 -> all outputs at reset values asynchronously, and a subsequent op completes correctly.
